apb_stream_mailbox: RTL and testbench
=====================================

# apb_stream_mailbox

APB completer peripheral hung off one master port of the SoC peripheral APB node, exposing a memory-mapped mailbox between the core and a streaming agent (accelerator, debug bridge, host link). APB writes push 32-bit words into a TX FIFO drained by a valid/ready stream; an optional RX FIFO filled by an inbound stream is popped by APB reads. Status, sticky error flags and a level interrupt complete the block.

## Interface
- APB_ADDR_WIDTH, 32, APB address width; only paddr[4:2] decoded.
- APB_DATA_WIDTH, 32, APB and stream data width.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128.
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- apb_slave  APB_BUS.Slave  APB_ADDR_WIDTH/APB_DATA_WIDTH  completer side: psel, penable, pwrite, paddr, pwdata in; prdata, pready, pslverr out.
- tx_data_o  output  APB_DATA_WIDTH  TX FIFO head.
- tx_valid_o  output  1  TX FIFO non-empty.
- tx_ready_i  input  1  consumer accepts head.
- rx_data_i  input  APB_DATA_WIDTH  inbound word.
- rx_valid_i  input  1  inbound word valid.
- rx_ready_o  output  1  RX FIFO not full.
- irq_o  output  1  registered level interrupt.

## Operation
- Access phase = psel & penable; all side effects happen only there. pready tied 1 (zero wait states); paddr[1:0] and bits above [4] ignored.
- Map (paddr[4:2]): 0 TXDATA (W: push; R: 0). 1 RXDATA (R: pop head; W: pslverr). 2 STATUS (R; W1C on [5:4]). 3 CTRL (RW). 4..7: prdata 0, pslverr 1, no side effect.
- STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_overflow sticky, [5] rx_underflow sticky, [15:8] tx_level, [23:16] rx_level, rest 0. Levels are clog2(FIFO_DEPTH)+1 bits, zero-extended.
- CTRL: [0] irq_rx_en, [1] irq_txempty_en (both RW); [2] tx_flush, [3] rx_flush write-1 pulses, read 0.
- TXDATA write while tx_full: word dropped, pslverr 1, tx_overflow set. RXDATA read while rx_empty: prdata 0, pslverr 1, rx_underflow set.
- Full/empty decided from registered state: TX write when full is rejected even if tx_ready_i pops the same cycle; rx_ready_o = !rx_full, so no RX push when full even if APB pops same cycle.
- TX write and TX pop same cycle (not full): both happen, level unchanged. Same for RX push/pop.
- Flush vs push same cycle: flush wins, pushed word lost, no overflow flag.
- irq_o next = (irq_rx_en & !rx_empty) | (irq_txempty_en & tx_empty).

## Timing
- Reset: FIFOs empty, flags and CTRL 0; tx_valid_o 0, tx_data_o 0, rx_ready_o 1, irq_o 0, prdata 0, pready 1, pslverr 0. Reset mid-transfer abandons it; contents lost.
- prdata/pslverr combinational in access phase from registered state.
- APB write accepted at edge N -> tx_valid_o/tx_data_o valid after N. RX handshake at N -> readable in access phase after N.
- STATUS reflects any push/pop/flush one cycle after the edge; irq_o lags STATUS by one further cycle.
- tx_data_o stable while tx_valid_o & !tx_ready_i.

## Configuration
- MAILBOX_RX_EN defined: RX FIFO, RXDATA, rx bits of STATUS/CTRL, rx_ready_o as above.
- Undefined: no RX storage; rx_ready_o 0; RXDATA access returns 0 with pslverr 1, no flag; STATUS [2],[5],[23:16] and CTRL [0],[3] read 0; STATUS[3] reads 1; irq from TX only.

## Structure
- mailbox_pkg: register offset constants, STATUS/CTRL bit-position constants, ctrl_t packed struct.
- One sub-module mailbox_fifo (sync FIFO, flush, level, full/empty), instantiated for TX and, under the macro, RX.

## Test plan
- Reset then read STATUS -> 0x0000_000A; irq_o 0, tx_valid_o 0.
- Write 0x11,0x22,0x33 to TXDATA with tx_ready_i 0 -> STATUS[15:8]=3; raise tx_ready_i -> tx_data_o 0x11,0x22,0x33 on consecutive cycles, then tx_valid_o 0.
- 9 TXDATA writes, FIFO_DEPTH 8, tx_ready_i 0 -> ninth pslverr 1, STATUS[4]=1; write 0x10 to STATUS -> bit 4 clears.
- Inbound 0xA5 with irq_rx_en=1 -> irq_o 1 two cycles after handshake; read RXDATA -> 0xA5, next read pslverr 1, prdata 0, STATUS[5]=1.
- Fill RX (8 words) -> rx_ready_o 0; RXDATA pop with rx_valid_i high same cycle -> push refused, level 7.
- TX write and CTRL tx_flush=1 back-to-back, then flush with reset asserted mid-burst -> levels 0, no overflow flag, outputs at reset values.

Source files
------------

// File: rtl/mailbox_pkg.sv
// Shared constants for the APB stream mailbox: register offsets (paddr[4:2]),
// STATUS/CTRL bit positions and the stored CTRL register layout.
package mailbox_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_TX_LVL   = 8;
  localparam int ST_RX_LVL   = 16;

  localparam int CT_IRQ_RX_EN  = 0;
  localparam int CT_IRQ_TXE_EN = 1;
  localparam int CT_TX_FLUSH   = 2;
  localparam int CT_RX_FLUSH   = 3;

  // Only the enables are stored; the flush bits are write-1 pulses.
  typedef struct packed {
    logic irq_txempty_en;
    logic irq_rx_en;
  } ctrl_t;

endpackage

// File: rtl/apb_bus.sv
// Minimal APB bus interface with a completer-side modport.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic                  pready;
  logic                  pslverr;

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/mailbox_fifo.sv
// Synchronous FIFO with flush, fill level and full/empty flags.
// Push is ignored when full, pop when empty; flush overrides both.
// Head data reads as zero while empty so the stream output is clean.
module mailbox_fifo
  import mailbox_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DW-1:0]           wdata_i,
  output logic [DW-1:0]           rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = cnt_q;

  // Pointer/count next state; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage has no reset; stale words are never visible (masked when empty).
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_stream_mailbox.sv
// APB mailbox between a core and a streaming agent.
// TXDATA writes feed a TX FIFO drained over valid/ready; with MAILBOX_RX_EN
// defined an RX FIFO filled by the inbound stream is popped by RXDATA reads.
// Without MAILBOX_RX_EN the RX side is absent and reads as permanently empty.
module apb_stream_mailbox
  import mailbox_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  APB_BUS.Slave                     apb_slave,
  output logic [APB_DATA_WIDTH-1:0] tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  input  logic [APB_DATA_WIDTH-1:0] rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic                      irq_o
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      acc, wr_acc, rd_acc;
  logic [2:0]                idx;

  logic                      tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_ovf_set;
  logic [LW-1:0]             tx_level;
  logic                      rx_full, rx_empty, rx_udf_set;
  logic [LW-1:0]             rx_level;
  logic [APB_DATA_WIDTH-1:0] rx_head;

  logic                      tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d, irq_q, irq_d;
  ctrl_t                     ctrl_q, ctrl_d;
  logic [APB_DATA_WIDTH-1:0] status, prdata;
  logic                      pslverr;

  assign paddr  = apb_slave.paddr;
  assign pwdata = apb_slave.pwdata;
  assign acc    = apb_slave.psel & apb_slave.penable;
  assign wr_acc = acc & apb_slave.pwrite;
  assign rd_acc = acc & ~apb_slave.pwrite;
  assign idx    = paddr[4:2];

  // Full is judged on registered state: a same-cycle stream pop does not
  // make room for the APB write.
  assign tx_push    = wr_acc & (idx == REG_TXDATA) & ~tx_full;
  assign tx_ovf_set = wr_acc & (idx == REG_TXDATA) & tx_full;
  assign tx_flush   = wr_acc & (idx == REG_CTRL) & pwdata[CT_TX_FLUSH];
  assign tx_pop     = ~tx_empty & tx_ready_i;
  assign tx_valid_o = ~tx_empty;

  mailbox_fifo #(.DW(APB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (tx_flush),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (pwdata),
    .rdata_o (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

`ifdef MAILBOX_RX_EN
  localparam bit RX_EN = 1'b1;
  logic rx_push, rx_pop, rx_flush;

  assign rx_push    = rx_valid_i & ~rx_full;
  assign rx_pop     = rd_acc & (idx == REG_RXDATA) & ~rx_empty;
  assign rx_udf_set = rd_acc & (idx == REG_RXDATA) & rx_empty;
  assign rx_flush   = wr_acc & (idx == REG_CTRL) & pwdata[CT_RX_FLUSH];
  assign rx_ready_o = ~rx_full;

  mailbox_fifo #(.DW(APB_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (rx_flush),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_data_i),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );
`else
  localparam bit RX_EN = 1'b0;
  assign rx_full    = 1'b0;
  assign rx_empty   = 1'b1;
  assign rx_level   = '0;
  assign rx_head    = '0;
  assign rx_udf_set = 1'b0;
  assign rx_ready_o = 1'b0;
`endif

  // STATUS word assembled from registered state.
  always_comb begin
    status                    = '0;
    status[ST_TX_FULL]        = tx_full;
    status[ST_TX_EMPTY]       = tx_empty;
    status[ST_RX_FULL]        = rx_full;
    status[ST_RX_EMPTY]       = rx_empty;
    status[ST_TX_OVF]         = tx_ovf_q;
    status[ST_RX_UDF]         = rx_udf_q;
    status[ST_TX_LVL +: LW]   = tx_level;
    status[ST_RX_LVL +: LW]   = rx_level;
  end

  // Sticky flags, CTRL enables and next interrupt level.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    ctrl_d   = ctrl_q;
    if (wr_acc && idx == REG_STATUS) begin
      if (pwdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
      if (pwdata[ST_RX_UDF]) rx_udf_d = 1'b0;
    end
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_udf_set) rx_udf_d = 1'b1;
    if (wr_acc && idx == REG_CTRL) begin
      ctrl_d.irq_rx_en      = pwdata[CT_IRQ_RX_EN] & RX_EN;
      ctrl_d.irq_txempty_en = pwdata[CT_IRQ_TXE_EN];
    end
    irq_d = (ctrl_q.irq_rx_en & ~rx_empty) | (ctrl_q.irq_txempty_en & tx_empty);
  end

  // Control/status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      ctrl_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= irq_d;
    end
  end

  // Read data and error response, driven only during the access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (acc) begin
      case (idx)
        REG_TXDATA: pslverr = apb_slave.pwrite & tx_full;
        REG_RXDATA: begin
          if (RX_EN && !apb_slave.pwrite && !rx_empty) prdata = rx_head;
          else                                         pslverr = 1'b1;
        end
        REG_STATUS: if (!apb_slave.pwrite) prdata = status;
        REG_CTRL: begin
          if (!apb_slave.pwrite) begin
            prdata[CT_IRQ_RX_EN]  = ctrl_q.irq_rx_en;
            prdata[CT_IRQ_TXE_EN] = ctrl_q.irq_txempty_en;
          end
        end
        default: pslverr = 1'b1;
      endcase
    end
  end

  assign apb_slave.prdata  = prdata;
  assign apb_slave.pslverr = pslverr;
  assign apb_slave.pready  = 1'b1;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_apb_stream_mailbox.sv
// Bench for apb_stream_mailbox: directed scenarios plus a randomized run,
// all checked against a queue-based model of the mailbox behaviour.
module tb_apb_stream_mailbox;
  localparam int D = 8;
`ifdef MAILBOX_RX_EN
  localparam bit RXE = 1'b1;
`else
  localparam bit RXE = 1'b0;
`endif
  localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CT = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb_stream_mailbox #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .apb_slave(apb),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] txq[$], rxq[$];
  bit          m_ovf, m_udf, m_rxen, m_txeen, m_irq;
  int          total = 0, bad = 0;
  logic [31:0] obs_rd, exp_rd;
  logic        obs_err, exp_err;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (txq.size() == D);
    s[1] = (txq.size() == 0);
    s[2] = RXE && (rxq.size() == D);
    s[3] = (rxq.size() == 0);
    s[4] = m_ovf;
    s[5] = m_udf;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_txhead();
    return (txq.size() != 0) ? txq[0] : 32'h0;
  endfunction

  // One clock: drive at negedge, record response and model expectation,
  // advance the model, return just after the rising edge.
  task automatic cycle(input bit sel, input bit en, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    bit acc, pop, push, fl, rpush, rpop, rfl, irq_n;
    logic [2:0] idx;
    @(negedge clk);
    apb.psel = sel; apb.penable = en; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
    #1;
    obs_rd = apb.prdata; obs_err = apb.pslverr;
    acc = sel && en; idx = a[4:2];
    exp_rd = '0; exp_err = 1'b0;
    if (acc) begin
      case (idx)
        3'd0: exp_err = wr && (txq.size() == D);
        3'd1: if (!wr && RXE && rxq.size() != 0) exp_rd = rxq[0]; else exp_err = 1'b1;
        3'd2: if (!wr) exp_rd = m_status();
        3'd3: if (!wr) begin exp_rd[0] = m_rxen; exp_rd[1] = m_txeen; end
        default: exp_err = 1'b1;
      endcase
    end
    irq_n = (m_rxen && rxq.size() != 0) || (m_txeen && txq.size() == 0);
    pop   = tx_ready && txq.size() != 0;
    push  = acc && wr && idx == 3'd0 && txq.size() < D;
    fl    = acc && wr && idx == 3'd3 && d[2];
    rpush = RXE && rx_valid && rxq.size() < D;
    rpop  = RXE && acc && !wr && idx == 3'd1 && rxq.size() != 0;
    rfl   = RXE && acc && wr && idx == 3'd3 && d[3];
    if (acc && wr && idx == 3'd0 && txq.size() == D) m_ovf = 1'b1;
    if (RXE && acc && !wr && idx == 3'd1 && rxq.size() == 0) m_udf = 1'b1;
    if (acc && wr && idx == 3'd2) begin
      if (d[4]) m_ovf = 1'b0;
      if (d[5]) m_udf = 1'b0;
    end
    if (acc && wr && idx == 3'd3) begin m_rxen = RXE && d[0]; m_txeen = d[1]; end
    if (fl) txq.delete();
    else begin
      if (pop)  void'(txq.pop_front());
      if (push) txq.push_back(d);
    end
    if (rfl) rxq.delete();
    else begin
      if (rpop)  void'(rxq.pop_front());
      if (rpush) rxq.push_back(rx_data);
    end
    m_irq = irq_n;
    @(posedge clk); #1;
  endtask

  task automatic idle(); cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); endtask
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d); cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask
  task automatic apb_rd(input logic [31:0] a);
    cycle(1'b1, 1'b0, 1'b0, a, 32'h0); cycle(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic rst_assert();
    @(negedge clk); #2;
    rst_n = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    txq.delete(); rxq.delete();
    m_ovf = 0; m_udf = 0; m_rxen = 0; m_txeen = 0; m_irq = 0;
  endtask
  task automatic rst_release();
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_assert(); #1;
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0 || irq !== 1'b0 || rx_ready !== RXE ||
        apb.pready !== 1'b1 || apb.pslverr !== 1'b0 || apb.prdata !== 32'h0) begin
      bad++; $display("FAIL reset_out: txv=%b txd=%h irq=%b rxr=%b prdy=%b err=%b prd=%h want 0 0 0 %b 1 0 0",
                      tx_valid, tx_data, irq, rx_ready, apb.pready, apb.pslverr, apb.prdata, RXE);
    end
    rst_release();
    apb_rd(A_ST);
    total++;
    if (obs_rd !== 32'h0000_000A || obs_err !== 1'b0) begin
      bad++; $display("FAIL reset_status: got %h err=%b want 0000000a err=0", obs_rd, obs_err);
    end
  endtask

  task automatic test_tx_order();
    logic [31:0] w[3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) apb_wr(A_TX, w[i]);
    apb_rd(A_ST);
    total++;
    if (obs_rd[15:8] !== 8'd3 || obs_rd[1:0] !== 2'b00) begin
      bad++; $display("FAIL tx_level3: got status %h want level 3, not empty/full", obs_rd);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== w[i]) begin
        bad++; $display("FAIL tx_order[%0d]: got v=%b d=%h want 1 %h", i, tx_valid, tx_data, w[i]);
      end
      idle();
    end
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin
      bad++; $display("FAIL tx_drained: got v=%b d=%h want 0 0", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] first, d;
    first = 32'h0;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = $urandom;
      if (i == 0) first = d;
      apb_wr(A_TX, d);
      total++;
      if (obs_err !== (i == 8)) begin
        bad++; $display("FAIL ovf_err[%0d]: got %b want %b", i, obs_err, (i == 8));
      end
    end
    apb_rd(A_ST);
    total++;
    if (obs_rd[4] !== 1'b1 || obs_rd[15:8] !== 8'd8 || obs_rd[0] !== 1'b1 || tx_data !== first) begin
      bad++; $display("FAIL ovf_status: got %h head=%h want ovf=1 lvl=8 full=1 head=%h", obs_rd, tx_data, first);
    end
    apb_wr(A_ST, 32'h10);
    apb_rd(A_ST);
    total++;
    if (obs_rd[4] !== 1'b0 || obs_rd[15:8] !== 8'd8) begin
      bad++; $display("FAIL ovf_w1c: got %h want ovf=0 lvl=8", obs_rd);
    end
    tx_ready = 1'b1;
    repeat (8) idle();
    tx_ready = 1'b0;
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain: got v=%b want 0", tx_valid); end
  endtask

  task automatic test_irq();
    apb_wr(A_CT, 32'h3);
    apb_rd(A_CT);
    total++;
    if (obs_rd !== (RXE ? 32'h3 : 32'h2) || irq !== 1'b1) begin
      bad++; $display("FAIL irq_ctrl: got ctrl=%h irq=%b want %h 1", obs_rd, irq, (RXE ? 32'h3 : 32'h2));
    end
    apb_wr(A_TX, 32'hCAFE_0001);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag: got %b want 1", irq); end
    idle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", irq); end
    tx_ready = 1'b1; idle(); tx_ready = 1'b0; idle();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1", irq); end
    apb_wr(A_CT, 32'h0); idle();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_disable: got %b want 0", irq); end
  endtask

  task automatic test_errors();
    apb_rd(A_RX);
    total++;
    if (obs_err !== 1'b1 || obs_rd !== 32'h0) begin
      bad++; $display("FAIL rx_empty_rd: got %h err=%b want 0 err=1", obs_rd, obs_err);
    end
    apb_rd(A_ST);
    total++;
    if (obs_rd[5] !== RXE) begin bad++; $display("FAIL udf_flag: got %b want %b", obs_rd[5], RXE); end
    apb_wr(A_ST, 32'h30);
    apb_wr(A_RX, 32'h1234);
    total++;
    if (obs_err !== 1'b1) begin bad++; $display("FAIL rx_wr_err: got %b want 1", obs_err); end
    for (int i = 4; i < 8; i++) begin
      apb_rd(32'(i * 4));
      total++;
      if (obs_err !== 1'b1 || obs_rd !== 32'h0) begin
        bad++; $display("FAIL unmapped_rd[%0d]: got %h err=%b want 0 err=1", i, obs_rd, obs_err);
      end
      apb_wr(32'(i * 4) | 32'hFFFF_0000, $urandom);
      total++;
      if (obs_err !== 1'b1) begin bad++; $display("FAIL unmapped_wr[%0d]: got %b want 1", i, obs_err); end
    end
    apb_wr(32'hABCD_0003, 32'h5A5A_0003);
    apb_rd(32'hFFFF_FFE0);
    total++;
    if (obs_err !== 1'b0 || obs_rd !== 32'h0 || tx_valid !== 1'b1 || tx_data !== 32'h5A5A_0003) begin
      bad++; $display("FAIL alias_tx: got rd=%h err=%b v=%b d=%h want 0 0 1 5a5a0003",
                      obs_rd, obs_err, tx_valid, tx_data);
    end
    apb_wr(A_CT, 32'h4);
  endtask

`ifdef MAILBOX_RX_EN
  task automatic test_rx();
    apb_wr(A_CT, 32'h1);
    rx_valid = 1'b1; rx_data = 32'hA5; idle(); rx_valid = 1'b0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_early: got %b want 0", irq); end
    idle();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b want 1", irq); end
    apb_rd(A_RX);
    total++;
    if (obs_rd !== 32'hA5 || obs_err !== 1'b0) begin
      bad++; $display("FAIL rx_pop: got %h err=%b want a5 0", obs_rd, obs_err);
    end
    apb_rd(A_RX);
    apb_rd(A_ST);
    total++;
    if (obs_rd[5] !== 1'b1) begin bad++; $display("FAIL rx_udf: got %h want bit5=1", obs_rd); end
    apb_wr(A_ST, 32'h20); apb_wr(A_CT, 32'h0);
    rx_valid = 1'b1;
    for (int i = 0; i < D; i++) begin rx_data = 32'(100 + i); idle(); end
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_rdy: got %b want 0", rx_ready); end
    rx_data = 32'hDEAD;
    apb_rd(A_RX);
    rx_valid = 1'b0;
    apb_rd(A_ST);
    total++;
    if (obs_rd[23:16] !== 8'd7 || obs_rd[2] !== 1'b0) begin
      bad++; $display("FAIL rx_pop_full: got %h want rx_level 7 not full", obs_rd);
    end
    cycle(1'b1, 1'b0, 1'b1, A_CT, 32'h8);
    rx_valid = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, A_CT, 32'h8);
    rx_valid = 1'b0;
    apb_rd(A_ST);
    total++;
    if (obs_rd[23:16] !== 8'd0 || obs_rd[3] !== 1'b1 || obs_rd[4] !== 1'b0) begin
      bad++; $display("FAIL rx_flush_push: got %h want rx_level 0 empty", obs_rd);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] r, a, d;
    logic [2:0]  idx;
    bit          wr;
    int          op;
    for (int it = 0; it < 300; it++) begin
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1);
      rx_data  = $urandom;
      op = $urandom_range(0, 9);
      d  = $urandom;
      wr = 1'b1;
      case (op)
        0, 1, 2, 3: idx = 3'd0;
        4: begin idx = 3'd2; wr = 1'b0; end
        5: begin idx = 3'd2; d = d & 32'h30; end
        6: begin idx = 3'd3; if ($urandom_range(0, 4) != 0) d[3:2] = 2'b00; end
        7: begin idx = 3'd1; wr = $urandom_range(0, 3) == 0; end
        8: begin idx = 3'($urandom_range(3, 7)); wr = $urandom_range(0, 1); end
        default: idx = 3'd0;
      endcase
      r = $urandom;
      a = {r[31:5], idx, r[1:0]};
      for (int ph = 0; ph < 2; ph++) begin
        if (op == 9) idle();
        else cycle(1'b1, ph == 1, wr, a, d);
        total++;
        if (obs_rd !== exp_rd || obs_err !== exp_err) begin
          bad++; $display("FAIL rand_apb[%0d]: got rd=%h err=%b want %h %b", it, obs_rd, obs_err, exp_rd, exp_err);
        end
        total++;
        if (tx_valid !== (txq.size() != 0) || tx_data !== m_txhead()) begin
          bad++; $display("FAIL rand_tx[%0d]: got v=%b d=%h want %b %h", it, tx_valid, tx_data,
                          (txq.size() != 0), m_txhead());
        end
        total++;
        if (irq !== m_irq || rx_ready !== (RXE && rxq.size() < D)) begin
          bad++; $display("FAIL rand_side[%0d]: got irq=%b rxr=%b want %b %b", it, irq, rx_ready,
                          m_irq, (RXE && rxq.size() < D));
        end
      end
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_flush_reset();
    tx_ready = 1'b0;
    apb_wr(A_CT, 32'h4);
    apb_wr(A_TX, 32'h55);
    apb_wr(A_CT, 32'h4);
    apb_rd(A_ST);
    total++;
    if (obs_rd !== 32'h0000_000A) begin bad++; $display("FAIL b2b_flush: got %h want 0000000a", obs_rd); end
    apb_wr(A_CT, 32'h2);
    for (int i = 0; i < 3; i++) apb_wr(A_TX, $urandom);
    cycle(1'b1, 1'b0, 1'b1, A_TX, 32'h77);
    rst_assert(); #1;
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0 || irq !== 1'b0 || rx_ready !== RXE ||
        apb.pslverr !== 1'b0 || apb.prdata !== 32'h0 || apb.pready !== 1'b1) begin
      bad++; $display("FAIL midburst_reset: txv=%b txd=%h irq=%b rxr=%b err=%b prd=%h",
                      tx_valid, tx_data, irq, rx_ready, apb.pslverr, apb.prdata);
    end
    rst_release();
    apb_rd(A_ST);
    total++;
    if (obs_rd !== 32'h0000_000A) begin bad++; $display("FAIL post_reset_status: got %h want 0000000a", obs_rd); end
    apb_rd(A_CT);
    total++;
    if (obs_rd !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl: got %h want 0", obs_rd); end
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    test_reset();
    test_tx_order();
    test_overflow();
    test_irq();
    test_errors();
`ifdef MAILBOX_RX_EN
    test_rx();
`endif
    test_random();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
